// File: rtl/codec_cfg_sequencer_if.sv
// ============================================================================
//  Module      : codec_cfg_sequencer_if
//  Description : Request, I2C-engine and status signals of the WM8731
//                configuration sequencer, bundled as one interface.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface codec_cfg_sequencer_if;
  // runtime requester side
  logic        req_valid;
  logic [6:0]  req_reg;
  logic [8:0]  req_data;
  logic        req_ready;
  // byte-level I2C write engine side
  logic        i2c_start;
  logic [23:0] i2c_word;
  logic        i2c_done;
  logic        i2c_nack;
  // status
  logic        init_done;
  logic        err;

  // the sequencer drives the engine and answers the requester
  modport master (
    input  req_valid, req_reg, req_data, i2c_done, i2c_nack,
    output req_ready, i2c_start, i2c_word, init_done, err
  );

  // the surrounding logic: requester, engine and status consumer
  modport slave (
    output req_valid, req_reg, req_data, i2c_done, i2c_nack,
    input  req_ready, i2c_start, i2c_word, init_done, err
  );
endinterface

`default_nettype wire

// File: rtl/codec_cfg_sequencer.sv
// ============================================================================
//  Module      : codec_cfg_sequencer
//  Description : Owns the I2C write engine for the WM8731 codec. Writes a
//                fixed 7-word init table after reset, then serves runtime
//                register writes. Inserts bus-free gaps, retries NACKed
//                writes and reports completion / abandonment.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module codec_cfg_sequencer #(
  parameter logic [7:0]  DEV_ADDR   = 8'h34,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned MAX_RETRY  = 3
) (
  input wire                    clk,
  input wire                    rst,
  codec_cfg_sequencer_if.master bus
);

  // gap counter runs 0 .. GAP_CYCLES-1
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // retry counter holds 0 .. MAX_RETRY, never narrower than 2 bits
  localparam int RETRY_W = ($clog2(MAX_RETRY + 1) > 2) ? $clog2(MAX_RETRY + 1) : 2;

  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_ONE   = GAP_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);
  localparam logic [2:0]         INIT_LEN  = 3'd7;

  typedef enum logic [2:0] {
    S_INIT_ISSUE = 3'd0,
    S_INIT_WAIT  = 3'd1,
    S_GAP        = 3'd2,
    S_READY      = 3'd3,
    S_RT_ISSUE   = 3'd4,
    S_RT_WAIT    = 3'd5,
    S_FAIL       = 3'd6
  } state_t;

  state_t               state_q,      state_d;
  logic [2:0]           index_q,      index_d;
  logic [RETRY_W-1:0]   retry_q,      retry_d;
  logic [GAP_W-1:0]     gap_cnt_q,    gap_cnt_d;
  logic                 rt_pending_q, rt_pending_d;
  logic                 req_ready_q,  req_ready_d;
  logic                 i2c_start_q,  i2c_start_d;
  logic [23:0]          i2c_word_q,   i2c_word_d;
  logic                 init_done_q,  init_done_d;
  logic                 err_q,        err_d;

  // codec init table: {reg[6:0], data[8:0]}; index 0 is the codec reset
  function automatic logic [15:0] init_entry(input logic [2:0] idx);
    logic [15:0] e;
    case (idx)
      3'd0:    e = {7'h0F, 9'h000};
      3'd1:    e = {7'h04, 9'h015};
      3'd2:    e = {7'h05, 9'h000};
      3'd3:    e = {7'h06, 9'h000};
      3'd4:    e = {7'h07, 9'h042};
      3'd5:    e = {7'h08, 9'h019};
      3'd6:    e = {7'h09, 9'h001};
      default: e = 16'h0000;
    endcase
    return e;
  endfunction

  // next-state and next-output logic; outputs are all registered, so an
  // ISSUE state loads the word and the start pulse appears in the WAIT cycle
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    retry_d      = retry_q;
    gap_cnt_d    = gap_cnt_q;
    rt_pending_d = rt_pending_q;
    req_ready_d  = 1'b0;
    i2c_start_d  = 1'b0;
    i2c_word_d   = i2c_word_q;
    init_done_d  = init_done_q;
    err_d        = err_q;

    case (state_q)
      S_INIT_ISSUE: begin
        i2c_word_d  = {DEV_ADDR, init_entry(index_q)};
        i2c_start_d = 1'b1;
        state_d     = S_INIT_WAIT;
      end

      S_INIT_WAIT: begin
        if (bus.i2c_done) begin
          if (!bus.i2c_nack) begin
            retry_d   = '0;
            index_d   = (index_q == INIT_LEN) ? index_q : index_q + 3'd1;
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end else if (retry_q < RETRY_MAX) begin
            // same index is re-issued after the gap
            retry_d   = retry_q + RETRY_ONE;
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end else begin
            // init cannot complete; park until reset
            err_d   = 1'b1;
            state_d = S_FAIL;
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (index_q != INIT_LEN) begin
            state_d = S_INIT_ISSUE;
          end else if (rt_pending_q) begin
            state_d = S_RT_ISSUE;
          end else begin
            state_d     = S_READY;
            req_ready_d = 1'b1;
            init_done_d = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_ONE;
        end
      end

      S_READY: begin
        if (bus.req_valid && req_ready_q) begin
          i2c_word_d   = {DEV_ADDR, bus.req_reg, bus.req_data};
          rt_pending_d = 1'b1;
          state_d      = S_RT_ISSUE;
        end else begin
          req_ready_d = 1'b1;
        end
      end

      S_RT_ISSUE: begin
        i2c_start_d = 1'b1;
        state_d     = S_RT_WAIT;
      end

      S_RT_WAIT: begin
        if (bus.i2c_done) begin
          gap_cnt_d = '0;
          state_d   = S_GAP;
          if (!bus.i2c_nack) begin
            retry_d      = '0;
            rt_pending_d = 1'b0;
          end else if (retry_q < RETRY_MAX) begin
            // keep the request pending so the gap leads back to RT_ISSUE
            retry_d = retry_q + RETRY_ONE;
          end else begin
            // runtime write is dropped; service continues after the gap
            err_d        = 1'b1;
            retry_d      = '0;
            rt_pending_d = 1'b0;
          end
        end
      end

      S_FAIL: begin
        init_done_d = 1'b0;
      end

      default: begin
        state_d = S_INIT_ISSUE;
      end
    endcase
  end

  // state, counters and registered outputs; reset restarts the init table
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_INIT_ISSUE;
      index_q      <= '0;
      retry_q      <= '0;
      gap_cnt_q    <= '0;
      rt_pending_q <= 1'b0;
      req_ready_q  <= 1'b0;
      i2c_start_q  <= 1'b0;
      i2c_word_q   <= '0;
      init_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      retry_q      <= retry_d;
      gap_cnt_q    <= gap_cnt_d;
      rt_pending_q <= rt_pending_d;
      req_ready_q  <= req_ready_d;
      i2c_start_q  <= i2c_start_d;
      i2c_word_q   <= i2c_word_d;
      init_done_q  <= init_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.i2c_start = i2c_start_q;
  assign bus.i2c_word  = i2c_word_q;
  assign bus.init_done = init_done_q;
  assign bus.err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_codec_cfg_sequencer.sv
// ============================================================================
//  Module      : tb_codec_cfg_sequencer
//  Description : Self-checking bench for codec_cfg_sequencer with an I2C
//                engine model, runtime request table, directed corner cases
//                and randomized init/runtime traffic against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_codec_cfg_sequencer;

  localparam int         GAP  = 16;
  localparam int         MAXR = 3;
  localparam logic [7:0] DEV  = 8'h34;

  logic clk = 1'b0;
  logic rst = 1'b0;

  codec_cfg_sequencer_if bus();

  codec_cfg_sequencer #(
    .DEV_ADDR   (DEV),
    .GAP_CYCLES (GAP),
    .MAX_RETRY  (MAXR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // engine model state and transaction log
  bit          eng_busy   = 1'b0;
  int          eng_cnt    = 0;
  int          eng_lat    = 50;
  logic [23:0] eng_word   = '0;
  bit          eng_nack   = 1'b0;
  bit          inject_req = 1'b0;
  bit          noise_en   = 1'b0;
  int          nack_left[logic [23:0]];
  logic [23:0] start_words[$];
  int          done_cyc[$];
  int          last_done_cyc = -1000000;
  logic [23:0] exp_words[$];

  // codec init table as written in the datasheet-level description
  logic [6:0] tbl_reg  [7] = '{7'h0F, 7'h04, 7'h05, 7'h06, 7'h07, 7'h08, 7'h09};
  logic [8:0] tbl_data [7] = '{9'h000, 9'h015, 9'h000, 9'h000, 9'h042, 9'h019, 9'h001};
  logic [23:0] lit_words [7] = '{24'h341E00, 24'h340815, 24'h340A00, 24'h340C00,
                                 24'h340E42, 24'h341019, 24'h341201};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // reference model: one write is attempted min(nacks+1, MAXR+1) times
  function automatic bit model_write(input logic [23:0] w, input int nacks);
    int tries;
    tries = (nacks > MAXR) ? MAXR + 1 : nacks + 1;
    for (int t = 0; t < tries; t++) exp_words.push_back(w);
    return nacks > MAXR;
  endfunction

  task automatic compare_log(input string name);
    int n;
    check({name, "_count"}, start_words.size(), exp_words.size());
    n = (start_words.size() < exp_words.size()) ? start_words.size() : exp_words.size();
    for (int i = 0; i < n; i++) check({name, "_word"}, start_words[i], exp_words[i]);
  endtask

  // I2C engine: done after eng_lat cycles, NACK policy per word
  initial begin
    bus.i2c_done = 1'b0;
    bus.i2c_nack = 1'b0;
    forever begin
      @(negedge clk);
      bus.i2c_done = 1'b0;
      bus.i2c_nack = noise_en && ($urandom_range(0, 3) == 0);
      if (!rst) begin
        eng_busy   = 1'b0;
        inject_req = 1'b0;
      end else if (eng_busy) begin
        check("word_stable", bus.i2c_word, eng_word);
        check("start_while_busy", bus.i2c_start, 1'b0);
        if (eng_cnt <= 1) begin
          bus.i2c_done = 1'b1;
          bus.i2c_nack = eng_nack;
          eng_busy     = 1'b0;
          done_cyc.push_back(cyc);
          last_done_cyc = cyc;
        end else begin
          eng_cnt--;
        end
      end else if (bus.i2c_start) begin
        start_words.push_back(bus.i2c_word);
        check_range("start_gap_idle", cyc - last_done_cyc - 1, GAP, 1000000000);
        eng_word = bus.i2c_word;
        eng_busy = 1'b1;
        eng_cnt  = eng_lat;
        eng_nack = 1'b0;
        if (nack_left.exists(eng_word) && nack_left[eng_word] != 0) begin
          eng_nack = 1'b1;
          if (nack_left[eng_word] > 0) nack_left[eng_word] = nack_left[eng_word] - 1;
        end
      end else if (inject_req) begin
        bus.i2c_done = 1'b1;
        bus.i2c_nack = 1'b1;
        inject_req   = 1'b0;
      end
    end
  end

  task automatic clear_log();
    start_words.delete();
    done_cyc.delete();
    exp_words.delete();
    last_done_cyc = -1000000;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    clear_log();
    nack_left.delete();
    rst = 1'b1;
  endtask

  task automatic wait_ready(input int budget, input string name);
    int k = 0;
    while (!bus.req_ready && k < budget) begin @(negedge clk); k++; end
    check(name, bus.req_ready, 1'b1);
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int k = 0;
    while (start_words.size() < n && k < budget) begin @(negedge clk); k++; end
    check(name, start_words.size() >= n, 1'b1);
  endtask

  // present a request, hold it until accepted, then drop it
  task automatic rt_req(input logic [6:0] r, input logic [8:0] d, input int budget,
                        output int waited, output int acc_cyc);
    bus.req_valid = 1'b1;
    bus.req_reg   = r;
    bus.req_data  = d;
    waited = 0;
    while (!bus.req_ready && waited < budget) begin @(negedge clk); waited++; end
    check("handshake_seen", bus.req_ready, 1'b1);
    acc_cyc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rt_ready_drop", bus.req_ready, 1'b0);
  endtask

  typedef struct {
    logic [6:0]  r;
    logic [8:0]  d;
    int          nacks;       // -1 = NACK forever
    logic [23:0] exp_word;
    int          exp_starts;
    logic        exp_err;
  } rt_vec_t;

  rt_vec_t vecs[6];

  initial begin
    int waited, acc, rise, nn, nacks_r[7];
    bit exhausted, ready_seen, idone_seen, exp_err;
    logic [6:0] rr;
    logic [8:0] rd;
    logic [23:0] w;

    vecs[0] = '{7'h02, 9'h079,  0, 24'h340479, 1, 1'b0};
    vecs[1] = '{7'h03, 9'h1FF,  1, 24'h3407FF, 2, 1'b0};
    vecs[2] = '{7'h00, 9'h017,  3, 24'h340017, 4, 1'b0};
    vecs[3] = '{7'h04, 9'h012, -1, 24'h340812, 4, 1'b1};
    vecs[4] = '{7'h7F, 9'h000,  0, 24'h34FE00, 1, 1'b1};
    vecs[5] = '{7'h06, 9'h067,  0, 24'h340C67, 1, 1'b1};

    bus.req_valid = 1'b0;
    bus.req_reg   = '0;
    bus.req_data  = '0;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_i2c_start", bus.i2c_start, 1'b0);
    check("rst_i2c_word",  bus.i2c_word,  24'h0);
    check("rst_init_done", bus.init_done, 1'b0);
    check("rst_err",       bus.err,       1'b0);

    // plain init, engine always ACKs after 50 cycles
    eng_lat = 50;
    do_reset();
    wait_ready(3000, "init_ready");
    rise = cyc;
    check_range("init_ready_after_gap", rise - last_done_cyc, GAP + 1, GAP + 2);
    check("init_done_at_ready", bus.init_done, 1'b1);
    repeat (40) @(negedge clk);
    check("init_count", start_words.size(), 7);
    for (int i = 0; i < 7 && i < start_words.size(); i++) check("init_word", start_words[i], lit_words[i]);
    check("init_err", bus.err, 1'b0);

    // runtime request table
    for (int v = 0; v < 6; v++) begin
      clear_log();
      eng_lat = 20 + v * 7;
      nack_left[vecs[v].exp_word] = vecs[v].nacks;
      rt_req(vecs[v].r, vecs[v].d, 50, waited, acc);
      check("rt_accept_immediate", waited, 0);
      wait_ready(4000, "rt_ready_back");
      rise = cyc;
      check_range("rt_ready_after_gap", rise - last_done_cyc, GAP + 1, GAP + 2);
      check("rt_count", start_words.size(), vecs[v].exp_starts);
      for (int i = 0; i < start_words.size(); i++) check("rt_word", start_words[i], vecs[v].exp_word);
      check("rt_err", bus.err, vecs[v].exp_err);
      check("rt_init_done", bus.init_done, 1'b1);
      nack_left.delete(vecs[v].exp_word);
    end

    // request held while busy is taken only once READY returns
    clear_log();
    eng_lat = 30;
    rt_req(7'h0A, 9'h0AA, 50, waited, acc);
    rt_req(7'h0B, 9'h155, 2000, waited, acc);
    check_range("held_req_wait", waited, 30 + GAP, 30 + GAP + 4);
    check_range("held_accept_after_gap", acc - last_done_cyc, GAP + 1, GAP + 2);
    check("held_starts_before_accept", start_words.size(), 1);
    wait_ready(2000, "held_ready_back");
    exp_words.delete();
    void'(model_write(24'h3414AA, 0));
    void'(model_write(24'h341755, 0));
    compare_log("held");

    // reset while index 4 is in INIT_WAIT, then spurious done in a gap
    eng_lat = 50;
    do_reset();
    wait_starts(5, 3000, "pre_reset_starts");
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_req_ready", bus.req_ready, 1'b0);
    check("midrst_i2c_start", bus.i2c_start, 1'b0);
    check("midrst_i2c_word",  bus.i2c_word,  24'h0);
    check("midrst_init_done", bus.init_done, 1'b0);
    check("midrst_err",       bus.err,       1'b0);
    repeat (2) @(negedge clk);
    clear_log();
    rst = 1'b1;
    wait_starts(1, 100, "restart_start");
    if (start_words.size() > 0) check("restart_word", start_words[0], 24'h341E00);
    begin
      int k = 0;
      while (done_cyc.size() < 1 && k < 200) begin @(negedge clk); k++; end
      check("restart_first_done", done_cyc.size() >= 1, 1'b1);
    end
    repeat (3) @(negedge clk);
    inject_req = 1'b1;
    wait_ready(3000, "restart_ready");
    exp_words.delete();
    for (int i = 0; i < 7; i++) void'(model_write(lit_words[i], 0));
    compare_log("restart");
    check("restart_err", bus.err, 1'b0);
    check("restart_init_done", bus.init_done, 1'b1);

    // NACK twice on index 2
    eng_lat = 25;
    do_reset();
    nack_left[24'h340A00] = 2;
    wait_ready(3000, "nack2_ready");
    exp_words.delete();
    for (int i = 0; i < 7; i++) void'(model_write({DEV, tbl_reg[i], tbl_data[i]}, (i == 2) ? 2 : 0));
    compare_log("nack2");
    check("nack2_err", bus.err, 1'b0);
    check("nack2_init_done", bus.init_done, 1'b1);

    // NACK forever on index 0 -> FAIL
    eng_lat = 20;
    do_reset();
    nack_left[24'h341E00] = -1;
    begin
      int k = 0;
      while (!bus.err && k < 1000) begin @(negedge clk); k++; end
    end
    check("fail_err", bus.err, 1'b1);
    ready_seen = 1'b0;
    idone_seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (bus.req_ready) ready_seen = 1'b1;
      if (bus.init_done) idone_seen = 1'b1;
    end
    check("fail_ready_seen", ready_seen, 1'b0);
    check("fail_init_done_seen", idone_seen, 1'b0);
    exp_words.delete();
    void'(model_write(24'h341E00, 99));
    compare_log("fail");

    // randomized init NACK patterns with nack noise
    noise_en = 1'b1;
    for (int t = 0; t < 4; t++) begin
      eng_lat = $urandom_range(1, 40);
      do_reset();
      exp_words.delete();
      exhausted = 1'b0;
      for (int i = 0; i < 7; i++) begin
        nn = $urandom_range(0, 10);
        nacks_r[i] = (nn < 7) ? 0 : nn - 6;
        w = {DEV, tbl_reg[i], tbl_data[i]};
        nack_left[w] = nacks_r[i];
        if (!exhausted) exhausted = model_write(w, nacks_r[i]);
      end
      begin
        int k = 0;
        while (!bus.req_ready && !bus.err && k < 6000) begin @(negedge clk); k++; end
      end
      repeat (200) @(negedge clk);
      compare_log("rand_init");
      check("rand_init_err", bus.err, exhausted);
      check("rand_init_done", bus.init_done, !exhausted);
    end

    // randomized runtime traffic after a clean init
    eng_lat = 10;
    do_reset();
    wait_ready(3000, "rand_rt_init_ready");
    exp_err = 1'b0;
    for (int t = 0; t < 6; t++) begin
      clear_log();
      rr = 7'($urandom_range(0, 127));
      rd = 9'($urandom_range(0, 511));
      nn = $urandom_range(0, 4);
      w  = {DEV, rr, rd};
      nack_left[w] = nn;
      eng_lat = $urandom_range(1, 20);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      if (model_write(w, nn)) exp_err = 1'b1;
      rt_req(rr, rd, 50, waited, acc);
      wait_ready(2000, "rand_rt_ready");
      compare_log("rand_rt");
      check("rand_rt_err", bus.err, exp_err);
      check("rand_rt_init_done", bus.init_done, 1'b1);
      nack_left.delete(w);
    end
    noise_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
